// File: rtl/scan_chain_pkg.sv
// Shared types and helpers for the scan chain driver.
package scan_chain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } scan_state_t;

    function automatic int cnt_w(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load shift register; shifts toward the MSB with new bits entering at the LSB.
module scan_shreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    input  logic         in_bit,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
        else if (shift)
            q <= {q[W-2:0], in_bit};
    end

endmodule

// File: rtl/scan_chain_driver.sv
// Loads a pattern into a scan chain, pulses one capture cycle, unloads and compares the response.
module scan_chain_driver
    import scan_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
    input  logic [CHAIN_LEN-1:0] MASK_IN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic [CHAIN_LEN-1:0] RESP_OUT,
    output logic                 RESP_VALID,
    output logic                 RESP_MATCH
);

    localparam int CW = cnt_w(CHAIN_LEN);

    scan_state_t          state, state_nx;
    logic [CW-1:0]        cnt;
    logic                 last_bit;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] exp_q, mask_q;
    logic                 accept;
    logic                 se_d, si_d, busy_d, rv_d;
    logic                 pat_unused;

    assign last_bit = (cnt == CW'(CHAIN_LEN - 1));
    assign accept   = (state == IDLE) && START;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        se_d     = 1'b0;
        si_d     = 1'b0;
        busy_d   = 1'b0;
        rv_d     = 1'b0;
        case (state)
            IDLE:      if (START) state_nx = SHIFT_IN;
            SHIFT_IN:  if (last_bit) state_nx = CAPTURE;
            CAPTURE:   state_nx = SHIFT_OUT;
            SHIFT_OUT: if (last_bit) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        se_d   = (state_nx == SHIFT_IN) || (state_nx == SHIFT_OUT);
        busy_d = (state_nx != IDLE);
        rv_d   = (state_nx == DONE);
        // SI is registered, so it is fed one bit ahead of the chain.
        if (accept)
            si_d = PAT_IN[CHAIN_LEN-1];
        else if ((state == SHIFT_IN) && !last_bit)
            si_d = pat_q[CHAIN_LEN-1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SE         <= 1'b0;
            SI         <= 1'b0;
            BUSY       <= 1'b0;
            RESP_VALID <= 1'b0;
        end else begin
            SE         <= se_d;
            SI         <= si_d;
            BUSY       <= busy_d;
            RESP_VALID <= rv_d;
        end
    end

    // Bit counter restarts on every state change and only advances while shifting.
    always_ff @(posedge CLK) begin
        if (RST || (state_nx != state))
            cnt <= '0;
        else if ((state == SHIFT_IN) || (state == SHIFT_OUT))
            cnt <= cnt + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            exp_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            exp_q  <= EXP_IN;
            mask_q <= MASK_IN;
        end
    end

    // The MSB was already handed to SI at acceptance, so the register holds the rest pre-shifted.
    scan_shreg #(.W(CHAIN_LEN)) u_pat (
        .clk    (CLK),
        .rst    (RST),
        .load   (accept),
        .shift  (state == SHIFT_IN),
        .d      ({PAT_IN[CHAIN_LEN-2:0], 1'b0}),
        .in_bit (1'b0),
        .q      (pat_q)
    );

    assign pat_unused = ^pat_q[CHAIN_LEN-2:0];

    scan_shreg #(.W(CHAIN_LEN)) u_resp (
        .clk    (CLK),
        .rst    (RST),
        .load   (1'b0),
        .shift  (state == SHIFT_OUT),
        .d      ('0),
        .in_bit (SO),
        .q      (RESP_OUT)
    );

    assign RESP_MATCH = (((RESP_OUT ^ exp_q) & mask_q) == '0);

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: a 4-flop inverting chain and a 32-flop constant-capture chain.
module tb_scan_chain_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start4, so4, se4, si4, busy4, rv4, rm4;
    logic [3:0]  pat4, exp4, mask4, resp4;
    logic        start32, so32, se32, si32, busy32, rv32, rm32;
    logic [31:0] pat32, exp32, mask32, resp32;

    scan_chain_driver #(.CHAIN_LEN(4)) dut4 (
        .CLK(clk), .RST(rst), .START(start4), .PAT_IN(pat4), .EXP_IN(exp4), .MASK_IN(mask4),
        .SO(so4), .SE(se4), .SI(si4), .BUSY(busy4), .RESP_OUT(resp4),
        .RESP_VALID(rv4), .RESP_MATCH(rm4)
    );

    scan_chain_driver #(.CHAIN_LEN(32)) dut32 (
        .CLK(clk), .RST(rst), .START(start32), .PAT_IN(pat32), .EXP_IN(exp32), .MASK_IN(mask32),
        .SO(so32), .SE(se32), .SI(si32), .BUSY(busy32), .RESP_OUT(resp32),
        .RESP_VALID(rv32), .RESP_MATCH(rm32)
    );

    // Chains: flop k feeds k+1; functional D is ~Q (4-bit) or a constant (32-bit).
    logic [3:0]  chain4  = '0;
    logic [31:0] chain32 = '0;
    always @(posedge clk) begin
        chain4  <= se4  ? {chain4[2:0], si4}   : ~chain4;
        chain32 <= se32 ? {chain32[30:0], si32} : 32'hDEAD_BEEF;
    end
    assign so4  = chain4[3];
    assign so32 = chain32[31];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int len(input int u);
        return (u == 0) ? 4 : 32;
    endfunction

    // Model: c = cycles since acceptance (0 = idle); outputs follow from the run timeline.
    int          c[2];
    logic [31:0] pm[2], em[2], mm[2], cm[2], rsp_m[2];

    always @(posedge clk) begin
        logic        st;
        logic [31:0] p, e, m;
        for (int u = 0; u < 2; u++) begin
            st = (u == 0) ? start4 : start32;
            p  = (u == 0) ? {28'b0, pat4}  : pat32;
            e  = (u == 0) ? {28'b0, exp4}  : exp32;
            m  = (u == 0) ? {28'b0, mask4} : mask32;
            if (rst) begin
                c[u] = 0; rsp_m[u] = '0; em[u] = '0; mm[u] = '0;
            end else if (c[u] == 0) begin
                if (st) begin
                    c[u] = 1; pm[u] = p; em[u] = e; mm[u] = m;
                    cm[u] = (u == 0) ? {28'b0, ~p[3:0]} : 32'hDEAD_BEEF;
                end
            end else if (c[u] == 2 * len(u) + 2) begin
                c[u] = 0;
            end else begin
                c[u]++;
                if (c[u] == 2 * len(u) + 2) rsp_m[u] = cm[u];
            end
        end
    end

    task automatic chk_unit(input int u, input logic se_a, input logic si_a, input logic busy_a,
                            input logic rv_a, input logic rm_a, input logic [31:0] resp_a);
        int   l, cc;
        logic e_se, e_si;
        l    = len(u);
        cc   = c[u];
        e_se = (cc >= 1 && cc <= l) || (cc >= l + 2 && cc <= 2 * l + 1);
        e_si = (cc >= 1 && cc <= l) ? pm[u][l - cc] : 1'b0;
        chk($sformatf("u%0d se c=%0d", u, cc), se_a, e_se);
        chk($sformatf("u%0d si c=%0d", u, cc), si_a, e_si);
        chk($sformatf("u%0d busy c=%0d", u, cc), busy_a, cc != 0);
        chk($sformatf("u%0d resp_valid c=%0d", u, cc), rv_a, cc == 2 * l + 2);
        if (cc == 0 || cc == 2 * l + 2)
            chk($sformatf("u%0d resp_out c=%0d", u, cc), resp_a, rsp_m[u]);
        if (cc == 2 * l + 2)
            chk($sformatf("u%0d resp_match", u), rm_a, ((rsp_m[u] ^ em[u]) & mm[u]) == '0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk_unit(0, se4, si4, busy4, rv4, rm4, {28'b0, resp4});
            chk_unit(1, se32, si32, busy32, rv32, rm32, resp32);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 4-bit run of pattern 1011; checks the hand-derived timeline literally.
    task automatic run4(input logic [3:0] e, input logic [3:0] m, input logic match, input bit hold);
        bit si_exp[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int nb = 0;
        pat4 = 4'b1011; exp4 = e; mask4 = m; start4 = 1'b1;
        step();
        if (!hold) start4 = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            if (busy4) nb++;
            if (j <= 4) begin
                chk($sformatf("lit si cyc%0d", j), si4, si_exp[j-1]);
                chk($sformatf("lit se cyc%0d", j), se4, 1'b1);
            end
            if (j == 5) chk("lit capture se", se4, 1'b0);
            if (j == 9) chk("lit rv early", rv4, 1'b0);
            if (j == 10) begin
                chk("lit rv", rv4, 1'b1);
                chk("lit resp", resp4, 4'b0100);
                chk("lit match", rm4, match);
            end
            if (j < 11) step();
        end
        chk("lit idle busy", busy4, 1'b0);
        chk("lit busy width", nb, 10);
        step();
        if (hold) begin
            chk("lit rerun accepted", busy4, 1'b1);
            start4 = 1'b0;
            repeat (11) step();
        end
    endtask

    initial begin
        rst = 1'b1;
        start4 = 0; pat4 = 0; exp4 = 0; mask4 = 0;
        start32 = 0; pat32 = 0; exp32 = 0; mask32 = 0;
        step(); step();
        chk_en = 1;
        chk("reset busy4", busy4, 1'b0);
        chk("reset se4", se4, 1'b0);
        chk("reset resp4", resp4, 4'b0);
        chk("reset rv32", rv32, 1'b0);
        rst = 1'b0;
        step();

        run4(4'b0100, 4'b1111, 1'b1, 0);
        run4(4'b0110, 4'b1111, 1'b0, 0);
        run4(4'b0110, 4'b1101, 1'b1, 0);
        run4(4'b0100, 4'b1111, 1'b1, 1);

        // Reset in the middle of SHIFT_IN
        pat4 = 4'b1011; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        chk("midrst se", se4, 1'b0);
        chk("midrst si", si4, 1'b0);
        chk("midrst busy", busy4, 1'b0);
        chk("midrst resp", resp4, 4'b0);
        rst = 1'b0;
        step();
        run4(4'b0100, 4'b1111, 1'b1, 0);

        // Long chain with constant capture
        pat32 = 32'hA5A5_0F0F; exp32 = 32'hDEAD_BEEF; mask32 = '1; start32 = 1'b1;
        step();
        start32 = 1'b0;
        for (int j = 1; j <= 66; j++) begin
            if (j == 65) chk("lit32 rv early", rv32, 1'b0);
            if (j == 66) begin
                chk("lit32 rv", rv32, 1'b1);
                chk("lit32 resp", resp32, 32'hDEAD_BEEF);
                chk("lit32 match", rm32, 1'b1);
            end
            step();
        end
        chk("lit32 idle", busy32, 1'b0);

        // Reset held with START high
        rst = 1'b1; start4 = 1'b1; start32 = 1'b1;
        repeat (4) begin
            step();
            chk("rsthold busy4", busy4, 1'b0);
            chk("rsthold busy32", busy32, 1'b0);
        end
        rst = 1'b0;
        step();
        chk("post-rst accept4", busy4, 1'b1);
        chk("post-rst accept32", busy32, 1'b1);
        start4 = 1'b0; start32 = 1'b0;
        repeat (70) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
